// File: rtl/pipeline_pkg.sv
// Shared definitions for the issue side of the register scoreboard:
// unit codes, scoreboard entry layout and the issue FSM state type.
package pipeline_pkg;

   localparam logic [1:0] UNIT_ALU = 2'd0;
   localparam logic [1:0] UNIT_MEM = 2'd1;
   localparam logic [1:0] UNIT_MUL = 2'd2;
   localparam logic [1:0] UNIT_BR  = 2'd3;

   localparam int unsigned SB_PENDING = 7;
   localparam int unsigned SB_UNIT_HI = 6;
   localparam int unsigned SB_UNIT_LO = 5;
   localparam int unsigned SB_POS_HI  = 4;
   localparam int unsigned SB_POS_LO  = 0;

   typedef enum logic [2:0] {
      IDLE,
      CHK_RS,
      CHK_RT,
      CHK_RD,
      ISSUE
   } issue_state_e;

endpackage

// File: rtl/hazard_check.sv
// Combinational register-readiness test shared by every check state:
// r0, a non-pending entry, or a same-cycle writeback clear all count as ready.
module hazard_check
   import pipeline_pkg::*;
#(
   parameter int unsigned REG_W = 5
) (
   input  logic [REG_W-1:0] addr,
   input  logic [7:0]       sb_data,
   input  logic [REG_W-1:0] clear_addr,
   input  logic             clear_en,
   output logic             ready
);

   // Only the pending bit matters for issue; unit/position feed other consumers.
   logic sb_fields_unused;
   assign sb_fields_unused = ^{sb_data[SB_UNIT_HI:SB_UNIT_LO], sb_data[SB_POS_HI:SB_POS_LO]};

   assign ready = (addr == '0)
                || !sb_data[SB_PENDING]
                || (clear_en && (clear_addr == addr));

endmodule

// File: rtl/issue_unit.sv
// In-order issue controller: checks rs/rt/rd through the scoreboard read port,
// stalls on hazards, then dispatches and reserves rd via the scoreboard write port.
module issue_unit
   import pipeline_pkg::*;
#(
   parameter int unsigned REG_W   = 5,
   parameter int unsigned STALL_W = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [REG_W-1:0]   in_rs,
   input  logic [REG_W-1:0]   in_rt,
   input  logic [REG_W-1:0]   in_rd,
   input  logic [1:0]         in_unit,
   input  logic               in_uses_rt,
   input  logic               in_writes_rd,
   output logic [REG_W-1:0]   sb_addr,
   input  logic [7:0]         sb_data,
   output logic [REG_W-1:0]   sb_writeaddr,
   output logic [1:0]         sb_registerstage,
   output logic               sb_enablewrite,
   input  logic [REG_W-1:0]   sb_clearaddr,
   input  logic               sb_enableclear,
   output logic               fu_valid,
   input  logic               fu_ready,
   output logic [REG_W-1:0]   fu_rs,
   output logic [REG_W-1:0]   fu_rt,
   output logic [REG_W-1:0]   fu_rd,
   output logic [1:0]         fu_unit,
   output logic [STALL_W-1:0] stall_count
);

   issue_state_e     state;
   logic [REG_W-1:0] rs_q, rt_q, rd_q;
   logic [1:0]       unit_q;
   logic             uses_rt_q, writes_rd_q;

   logic [REG_W-1:0] chk_addr;
   logic             chk_ok;
   logic             rd_needed;
   logic             issuing;
   logic             stall;

   assign rd_needed = writes_rd_q && (rd_q != '0);

   always_comb begin
      chk_addr = '0;
      case (state)
         CHK_RS:  chk_addr = rs_q;
         CHK_RT:  chk_addr = rt_q;
         CHK_RD:  chk_addr = rd_q;
         default: chk_addr = '0;
      endcase
   end

   hazard_check #(.REG_W(REG_W)) u_hazard_check (
      .addr       (chk_addr),
      .sb_data    (sb_data),
      .clear_addr (sb_clearaddr),
      .clear_en   (sb_enableclear),
      .ready      (chk_ok)
   );

   assign issuing = (state == ISSUE) && fu_ready;
   assign stall   = ((state == CHK_RS || state == CHK_RT || state == CHK_RD) && !chk_ok)
                 || ((state == ISSUE) && !fu_ready);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         unit_q      <= '0;
         uses_rt_q   <= 1'b0;
         writes_rd_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  rs_q        <= in_rs;
                  rt_q        <= in_rt;
                  rd_q        <= in_rd;
                  unit_q      <= in_unit;
                  uses_rt_q   <= in_uses_rt;
                  writes_rd_q <= in_writes_rd;
                  state       <= CHK_RS;
               end
            end
            CHK_RS: begin
               if (chk_ok) begin
                  if (uses_rt_q)      state <= CHK_RT;
                  else if (rd_needed) state <= CHK_RD;
                  else                state <= ISSUE;
               end
            end
            CHK_RT: begin
               if (chk_ok) state <= rd_needed ? CHK_RD : ISSUE;
            end
            CHK_RD: begin
               if (chk_ok) state <= ISSUE;
            end
            ISSUE: begin
               if (fu_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_count <= '0;
      end else if (stall && (stall_count != '1)) begin
         stall_count <= stall_count + 1'b1;
      end
   end

   assign in_ready         = (state == IDLE);
   assign sb_addr          = chk_addr;
   assign fu_valid         = issuing;
   assign fu_rs            = issuing ? rs_q   : '0;
   assign fu_rt            = issuing ? rt_q   : '0;
   assign fu_rd            = issuing ? rd_q   : '0;
   assign fu_unit          = issuing ? unit_q : '0;
   assign sb_enablewrite   = issuing && rd_needed;
   assign sb_writeaddr     = sb_enablewrite ? rd_q   : '0;
   assign sb_registerstage = sb_enablewrite ? unit_q : '0;

endmodule

// File: tb/tb_issue_unit.sv
// Scoreboard-driven bench for issue_unit: a small register-scoreboard model
// answers reads, expected dispatches are queued at drive time and popped on fu_valid.
module tb_issue_unit;

   localparam int unsigned REG_W   = 5;
   localparam int unsigned STALL_W = 3;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [REG_W-1:0]   in_rs = '0, in_rt = '0, in_rd = '0;
   logic [1:0]         in_unit = '0;
   logic               in_uses_rt = 1'b0, in_writes_rd = 1'b0;
   logic [REG_W-1:0]   sb_addr;
   logic [7:0]         sb_data;
   logic [REG_W-1:0]   sb_writeaddr;
   logic [1:0]         sb_registerstage;
   logic               sb_enablewrite;
   logic [REG_W-1:0]   sb_clearaddr;
   logic               sb_enableclear;
   logic               fu_valid;
   logic               fu_ready = 1'b1;
   logic [REG_W-1:0]   fu_rs, fu_rt, fu_rd;
   logic [1:0]         fu_unit;
   logic [STALL_W-1:0] stall_count;

   logic [31:0]        pend = '0;
   logic               ssc_arm = 1'b0;
   logic [REG_W-1:0]   ssc_reg = '0;

   int total = 0;
   int bad   = 0;
   int n_fu  = 0;
   int n_we  = 0;

   typedef struct {
      logic [REG_W-1:0] rs, rt, rd;
      logic [1:0]       unit;
      logic             we;
      int               lat;
   } exp_t;
   exp_t sbq[$];

   always #5 clock = ~clock;

   issue_unit #(.REG_W(REG_W), .STALL_W(STALL_W)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_unit(in_unit),
      .in_uses_rt(in_uses_rt), .in_writes_rd(in_writes_rd),
      .sb_addr(sb_addr), .sb_data(sb_data),
      .sb_writeaddr(sb_writeaddr), .sb_registerstage(sb_registerstage),
      .sb_enablewrite(sb_enablewrite),
      .sb_clearaddr(sb_clearaddr), .sb_enableclear(sb_enableclear),
      .fu_valid(fu_valid), .fu_ready(fu_ready),
      .fu_rs(fu_rs), .fu_rt(fu_rt), .fu_rd(fu_rd), .fu_unit(fu_unit),
      .stall_count(stall_count)
   );

   always_comb begin
      sb_data        = pend[sb_addr] ? {1'b1, 2'b01, sb_addr} : 8'h00;
      sb_clearaddr   = ssc_reg;
      sb_enableclear = ssc_arm && (sb_addr == ssc_reg);
   end

   always begin
      @(negedge clock);
      #2;
      if (fu_valid)       n_fu = n_fu + 1;
      if (sb_enablewrite) n_we = n_we + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      if (obs !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset    = 1'b0;
      pend     = '0;
      ssc_arm  = 1'b0;
      fu_ready = 1'b1;
      in_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic accept(input logic [REG_W-1:0] rs, rt, rd, input logic [1:0] unit,
                         input logic uses, writes);
      @(negedge clock);
      in_rs = rs; in_rt = rt; in_rd = rd; in_unit = unit;
      in_uses_rt = uses; in_writes_rd = writes;
      in_valid = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
   endtask

   // hz_reg is released from cycle hz_k on; fu_ready rises from cycle rdy_k on.
   task automatic run_instr(input string tag,
                            input logic [REG_W-1:0] rs, rt, rd, input logic [1:0] unit,
                            input logic uses, writes, input int lat,
                            input int rdy_k, input int hz_reg, input int hz_k);
      exp_t e, got;
      int   fu0, we0;
      logic done;
      e.rs = rs; e.rt = rt; e.rd = rd; e.unit = unit;
      e.we = writes && (rd != 0);
      e.lat = lat;
      sbq.push_back(e);
      fu0 = n_fu; we0 = n_we;
      done = 1'b0;
      accept(rs, rt, rd, unit, uses, writes);
      for (int k = 1; k <= 40 && !done; k++) begin
         @(negedge clock);
         if (hz_reg >= 0 && k >= hz_k) pend[hz_reg] = 1'b0;
         fu_ready = (k >= rdy_k);
         #1;
         if (k == 1) check({tag, ".busy"}, in_ready, 0);
         if (fu_valid) begin
            done = 1'b1;
            got = sbq.pop_front();
            check({tag, ".lat"},   k,              got.lat);
            check({tag, ".rs"},    fu_rs,          got.rs);
            check({tag, ".rt"},    fu_rt,          got.rt);
            check({tag, ".rd"},    fu_rd,          got.rd);
            check({tag, ".unit"},  fu_unit,        got.unit);
            check({tag, ".we"},    sb_enablewrite, got.we);
            check({tag, ".waddr"}, sb_writeaddr,     got.we ? got.rd : 0);
            check({tag, ".stage"}, sb_registerstage, got.we ? got.unit : 0);
         end
      end
      check({tag, ".dispatched"}, done, 1);
      fu_ready = 1'b1;
      @(negedge clock);
      #3;
      check({tag, ".ready_after"}, in_ready, 1);
      check({tag, ".fu_pulses"},   n_fu - fu0, 1);
      check({tag, ".we_pulses"},   n_we - we0, e.we);
   endtask

   initial begin
      int fu0, we0;

      do_reset();
      #1;
      check("rst.in_ready", in_ready, 1);
      check("rst.fu_valid", fu_valid, 0);
      check("rst.we",       sb_enablewrite, 0);
      check("rst.stall",    stall_count, 0);
      check("rst.sb_addr",  sb_addr, 0);

      // No hazards, all three checks
      run_instr("basic", 5'd3, 5'd4, 5'd5, 2'd1, 1'b1, 1'b1, 4, 1, -1, 0);
      check("basic.stall", stall_count, 0);

      // r4 pending for three cycles in CHK_RT
      do_reset();
      pend[4] = 1'b1;
      run_instr("raw", 5'd3, 5'd4, 5'd5, 2'd0, 1'b1, 1'b1, 7, 1, 4, 5);
      check("raw.stall", stall_count, 3);

      // rd pending but cleared by writeback in the same cycle
      do_reset();
      pend[5] = 1'b1; ssc_reg = 5'd5; ssc_arm = 1'b1;
      run_instr("waw_clr", 5'd3, 5'd4, 5'd5, 2'd2, 1'b1, 1'b1, 4, 1, -1, 0);
      check("waw_clr.stall", stall_count, 0);
      ssc_arm = 1'b0; pend[5] = 1'b0;

      // r0 everywhere: never pending, no reservation
      do_reset();
      pend[0] = 1'b1;
      run_instr("r0", 5'd0, 5'd7, 5'd0, 2'd3, 1'b0, 1'b1, 2, 1, -1, 0);
      check("r0.stall", stall_count, 0);

      // rt unused, rd real
      do_reset();
      run_instr("nort", 5'd2, 5'd31, 5'd6, 2'd0, 1'b0, 1'b1, 3, 1, -1, 0);

      // Functional unit busy for two ISSUE cycles
      do_reset();
      run_instr("fubusy", 5'd1, 5'd2, 5'd9, 2'd2, 1'b1, 1'b1, 6, 6, -1, 0);
      check("fubusy.stall", stall_count, 2);

      // Stall counter saturates
      do_reset();
      pend[4] = 1'b1;
      run_instr("sat", 5'd3, 5'd4, 5'd5, 2'd1, 1'b1, 1'b1, 14, 1, 4, 12);
      check("sat.stall", stall_count, 7);

      // Reset mid-check discards the instruction
      do_reset();
      pend[4] = 1'b1;
      fu0 = n_fu; we0 = n_we;
      accept(5'd6, 5'd4, 5'd8, 2'd0, 1'b1, 1'b1);
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("mid_rst.in_ready", in_ready, 1);
      check("mid_rst.fu_valid", fu_valid, 0);
      check("mid_rst.we",       sb_enablewrite, 0);
      check("mid_rst.stall",    stall_count, 0);
      @(negedge clock);
      reset = 1'b1;
      pend  = '0;
      repeat (8) @(negedge clock);
      #3;
      check("mid_rst.fu_pulses", n_fu - fu0, 0);
      check("mid_rst.we_pulses", n_we - we0, 0);
      check("mid_rst.stall_after", stall_count, 0);
      check("mid_rst.idle", in_ready, 1);
      check("sbq.empty", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
